dpram_fifo_ctrl: RTL

- Synchronous FIFO controller that sequences one simple dual-port RAM (write port A, read port B).
- The RAM's read port has a registered address, so read data appears one cycle after an issue.
- The block drives the RAM ports and hides that read latency behind a 2-entry output buffer.
- Producers and consumers see valid/ready streams with full throughput. It is used for the cache refill and writeback queues in the memory pipeline.

---
 rtl/mem_pkg.sv | 14 +
 rtl/fifo_out_buf2.sv | 31 +++
 rtl/dpram_fifo_ctrl.sv | 72 +++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: width helpers and elaboration-time depth check shared by memory-pipeline queues
`define MEM_ASSERT_POW2(d) \
  if (((d) < 2) || (((d) & ((d) - 1)) != 0)) begin : g_bad_depth \
    $error("DEPTH must be a power of 2 and at least 2"); \
  end

package mem_pkg;
  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth);
  endfunction
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth + 3);
  endfunction
endpackage

// File: rtl/fifo_out_buf2.sv
// fifo_out_buf2: two-entry output buffer that absorbs the RAM read latency
module fifo_out_buf2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             wr,
  input  logic [WIDTH-1:0] din,
  input  logic             rd,
  output logic             valid,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       ocnt
);
  logic [WIDTH-1:0] mem [2];
  logic             hd;
  logic             take;
  assign valid = ocnt != 2'd0;
  assign dout  = mem[hd];
  assign take  = rd & valid;
  always_ff @(posedge clk) begin
    if (clr) begin
      ocnt <= 2'd0;
      hd   <= 1'b0;
    end else begin
      ocnt <= ocnt + 2'(wr) - 2'(take);
      hd   <= hd ^ take;
    end
    // a write only ever lands with ocnt <= 1, so the tail is hd ^ ocnt[0]
    if (wr && !clr) mem[hd ^ ocnt[0]] <= din;
  end
endmodule

// File: rtl/dpram_fifo_ctrl.sv
// dpram_fifo_ctrl: valid/ready FIFO sequencing a simple dual-port RAM with registered read address
module dpram_fifo_ctrl
  import mem_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 16,
  localparam int PTR_W = fifo_ptr_w(DEPTH),
  localparam int CNT_W = fifo_cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count,
  output logic             ram_ena,
  output logic             ram_wea,
  output logic [PTR_W-1:0] ram_addra,
  output logic [WIDTH-1:0] ram_dina,
  output logic             ram_enb,
  output logic [PTR_W-1:0] ram_addrb,
  input  logic [WIDTH-1:0] ram_doutb
);
  `MEM_ASSERT_POW2(DEPTH)
  logic [PTR_W-1:0] wptr, rptr;
  logic [PTR_W:0]   slots, pend;
  logic             infl;
  logic [1:0]       ocnt;
  logic             clr, push, pop, issue;
  assign clr      = !rst_n || flush;
  assign in_ready = !clr && (slots != (PTR_W+1)'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  // keep obuf occupancy plus in-flight read at most 2 once this issue lands
  assign issue    = !clr && (pend != '0) && ({1'b0, ocnt} + {2'b0, infl} <= 3'd1 + {2'b0, pop});
  assign ram_ena   = push;
  assign ram_wea   = push;
  assign ram_addra = wptr;
  assign ram_dina  = in_data;
  assign ram_enb   = issue;
  assign ram_addrb = rptr;
  assign count     = CNT_W'(slots) + CNT_W'(ocnt);
  always_ff @(posedge clk) begin
    if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      slots <= '0;
      pend  <= '0;
      infl  <= 1'b0;
    end else begin
      wptr  <= wptr + PTR_W'(push);
      rptr  <= rptr + PTR_W'(issue);
      slots <= slots + (PTR_W+1)'(push) - (PTR_W+1)'(infl);
      pend  <= pend + (PTR_W+1)'(push) - (PTR_W+1)'(issue);
      infl  <= issue;
    end
  end
  fifo_out_buf2 #(.WIDTH(WIDTH)) u_obuf (
    .clk   (clk),
    .clr   (clr),
    .wr    (infl),
    .din   (ram_doutb),
    .rd    (pop),
    .valid (out_valid),
    .dout  (out_data),
    .ocnt  (ocnt)
  );
endmodule
